mapper_xlate: RTL and testbench

Synchronous bank-translation and trap-address unit downstream of the mapper control CPLD logic. It consumes that logic's strobes: `bank_wr_n`, `trap_addr_wr_n`, `trap_addr_rd_n`, `capture_addr` and `translate_addr`.
- Holds four page (bank) registers and produces the translated physical page for each CPU access.
- Latches the CPU address of an I/O violation or NMI capture and returns it byte-wise to the trap handler.
- Drives `trap_pending` until the handler has read the full address.

---
 rtl/mapper_pkg.sv | 24 ++
 rtl/mapper_xlate_if.sv | 37 +++
 rtl/mapper_xlate_strobe_sync.sv | 49 ++++
 rtl/mapper_xlate.sv | 235 +++++++++++++++++++++++
 tb/tb_mapper_xlate.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mapper_pkg.sv
// mapper_pkg: shared types and constants for the mapper translation unit.
//   trap_state_t  : trap FSM encoding (IDLE, HELD_LO, HELD_HI)
//   SEL_LO/SEL_HI : byte select values on lo_addr[0] for trap readback
//   NUM_BANKS     : number of page registers (one per 16 KiB CPU window)
//   bank_identity : reset value of a page register (identity map)
package mapper_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD_LO = 2'd1,
        HELD_HI = 2'd2
    } trap_state_t;

    localparam logic SEL_LO    = 1'b0;
    localparam logic SEL_HI    = 1'b1;
    localparam int   NUM_BANKS = 4;

    // Page register idx resets to physical page idx. Returned wide so the
    // caller can slice it to whatever PAGE_BITS it is built with.
    function automatic logic [31:0] bank_identity(input int idx);
        return 32'(idx);
    endfunction

endpackage

// File: rtl/mapper_xlate_if.sv
// mapper_xlate_if: CPU-side bus between the mapper control logic and
// mapper_xlate.
//   master : drives cpu_addr, data_in, lo_addr, the four strobes and
//            translate_addr; observes the results.
//   slave  : mapper_xlate itself; drives data_out, data_oe, phys_page,
//            trap_pending and overrun_cnt.
interface mapper_xlate_if #(
    parameter int PAGE_BITS = 8
);
    logic [15:0]          cpu_addr;
    logic [7:0]           data_in;
    logic [1:0]           lo_addr;
    logic                 bank_wr_n;
    logic                 trap_addr_wr_n;
    logic                 trap_addr_rd_n;
    logic                 capture_addr;
    logic                 translate_addr;
    logic [7:0]           data_out;
    logic                 data_oe;
    logic [PAGE_BITS-1:0] phys_page;
    logic                 trap_pending;
    logic [3:0]           overrun_cnt;

    modport master (
        output cpu_addr, data_in, lo_addr,
        output bank_wr_n, trap_addr_wr_n, trap_addr_rd_n,
        output capture_addr, translate_addr,
        input  data_out, data_oe, phys_page, trap_pending, overrun_cnt
    );

    modport slave (
        input  cpu_addr, data_in, lo_addr,
        input  bank_wr_n, trap_addr_wr_n, trap_addr_rd_n,
        input  capture_addr, translate_addr,
        output data_out, data_oe, phys_page, trap_pending, overrun_cnt
    );
endinterface

// File: rtl/mapper_xlate_strobe_sync.sv
// strobe_sync: STAGES-deep synchronizer for one asynchronous strobe with
// single-cycle edge pulses.
//   clk, reset : system clock, synchronous active-high reset
//   async_i    : raw strobe from the bus
//   sync_o     : synchronized level (STAGES clocks behind async_i)
//   rise_o     : one-cycle pulse, combinational, when sync_o goes 0->1
//   fall_o     : one-cycle pulse, combinational, when sync_o goes 1->0
// STAGES must be at least 2. RESET_VAL is the idle level of the strobe so
// that reset never manufactures an edge.
module strobe_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) sync_q[gi] <= RESET_VAL;
                    else       sync_q[gi] <= async_i;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (reset) sync_q[gi] <= RESET_VAL;
                    else       sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) prev_q <= RESET_VAL;
        else       prev_q <= sync_q[STAGES-1];
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;
endmodule

// File: rtl/mapper_xlate.sv
// mapper_xlate: page translation and trap-address capture/readback.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : mapper_xlate_if.slave
//       in  cpu_addr, data_in, lo_addr, bank_wr_n, trap_addr_wr_n,
//           trap_addr_rd_n, capture_addr, translate_addr
//       out data_out, data_oe, phys_page, trap_pending, overrun_cnt
// Build option: define MAPPER_OVERRUN_EN to count captures lost while a
// trap address is still held (overrun_cnt, saturating at 15); without it
// overrun_cnt is constant 0.
module mapper_xlate
    import mapper_pkg::*;
#(
    parameter int PAGE_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    mapper_xlate_if.slave  bus
);
    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_HELD_LO = HELD_LO;
    localparam logic [1:0] ST_HELD_HI = HELD_HI;
    localparam int         PIPE_W     = 16 + 8 + 2;

    // ---------------- strobe synchronizers ----------------
    logic bank_sync, bank_rise, bank_fall;
    logic viol_sync, viol_rise, viol_fall;
    logic rd_sync,   rd_rise,   rd_fall;
    logic cap_sync,  cap_rise,  cap_fall;

    strobe_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_bank (
        .clk(clk), .reset(reset), .async_i(bus.bank_wr_n),
        .sync_o(bank_sync), .rise_o(bank_rise), .fall_o(bank_fall)
    );
    strobe_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_viol (
        .clk(clk), .reset(reset), .async_i(bus.trap_addr_wr_n),
        .sync_o(viol_sync), .rise_o(viol_rise), .fall_o(viol_fall)
    );
    strobe_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rd (
        .clk(clk), .reset(reset), .async_i(bus.trap_addr_rd_n),
        .sync_o(rd_sync), .rise_o(rd_rise), .fall_o(rd_fall)
    );
    strobe_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cap (
        .clk(clk), .reset(reset), .async_i(bus.capture_addr),
        .sync_o(cap_sync), .rise_o(cap_rise), .fall_o(cap_fall)
    );

    // Only some edges/levels are meaningful; the rest are sunk here.
    logic unused_edges;
    assign unused_edges = &{1'b0, bank_sync, bank_rise, viol_sync, viol_rise,
                            cap_sync, cap_fall};

    // ---------------- address/data alignment pipeline ----------------
    // Same depth as the strobe synchronizers, so the address and data seen
    // with an edge pulse are the ones present when the strobe moved.
    logic [PIPE_W-1:0] pipe_in;
    logic [PIPE_W-1:0] pipe_q [SYNC_STAGES];
    logic [15:0]       cpu_addr_s;
    logic [7:0]        data_in_s;
    logic [1:0]        lo_addr_s;

    assign pipe_in = {bus.cpu_addr, bus.data_in, bus.lo_addr};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_pipe
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) pipe_q[gi] <= '0;
                    else       pipe_q[gi] <= pipe_in;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (reset) pipe_q[gi] <= '0;
                    else       pipe_q[gi] <= pipe_q[gi-1];
                end
            end
        end
    endgenerate

    assign {cpu_addr_s, data_in_s, lo_addr_s} = pipe_q[SYNC_STAGES-1];

    // ---------------- events ----------------
    logic bank_wr_evt, capture_evt, rd_start_evt, rd_end_evt;
    assign bank_wr_evt  = bank_fall;
    assign capture_evt  = viol_fall | cap_rise;
    assign rd_start_evt = rd_fall;
    assign rd_end_evt   = rd_rise;

    // ---------------- bank registers ----------------
    logic [PAGE_BITS-1:0] bank_q [NUM_BANKS];
    logic [PAGE_BITS-1:0] bank_wdata;

    // data_in zero-extended or truncated to the page width.
    always_comb begin
        bank_wdata = '0;
        for (int i = 0; i < PAGE_BITS && i < 8; i++) begin
            bank_wdata[i] = data_in_s[i];
        end
    end

    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            localparam logic [31:0] RST_VAL = bank_identity(gi);
            always_ff @(posedge clk) begin
                if (reset) begin
                    bank_q[gi] <= RST_VAL[PAGE_BITS-1:0];
                end else if (bank_wr_evt && lo_addr_s == 2'(gi)) begin
                    bank_q[gi] <= bank_wdata;
                end
            end
        end
    endgenerate

    // ---------------- translation ----------------
    // Uses the raw bus: the clock is fast enough relative to the CPU that
    // cpu_addr is stable by the time it is sampled. A bank write landing in
    // the same cycle is seen one cycle later because bank_q is read here
    // before it updates.
    logic [PAGE_BITS-1:0] phys_page_q, phys_page_d;

    always_comb begin
        phys_page_d = '0;
        if (bus.translate_addr) begin
            phys_page_d = bank_q[bus.cpu_addr[15:14]];
        end else begin
            phys_page_d[1:0] = bus.cpu_addr[15:14];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) phys_page_q <= '0;
        else       phys_page_q <= phys_page_d;
    end

    // ---------------- trap FSM ----------------
    logic [1:0]  state_q, state_d;
    logic [15:0] trap_addr_q, trap_addr_d;
    logic        overrun_evt;

    always_comb begin
        state_d     = state_q;
        trap_addr_d = trap_addr_q;
        overrun_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture_evt) begin
                    state_d     = ST_HELD_LO;
                    trap_addr_d = cpu_addr_s;
                end
            end
            ST_HELD_LO: begin
                if (rd_end_evt && lo_addr_s[0] == SEL_LO) begin
                    state_d = ST_HELD_HI;
                end
                if (capture_evt) begin
                    overrun_evt = 1'b1;
                end
            end
            ST_HELD_HI: begin
                if (rd_end_evt && lo_addr_s[0] == SEL_HI) begin
                    // Readback completes this cycle, so a coincident
                    // capture is accepted as a fresh trap, not an overrun.
                    if (capture_evt) begin
                        state_d     = ST_HELD_LO;
                        trap_addr_d = cpu_addr_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (capture_evt) begin
                    overrun_evt = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            trap_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            trap_addr_q <= trap_addr_d;
        end
    end

    // ---------------- readback ----------------
    // The byte is frozen at read start. In the start cycle itself data_oe
    // is already high, so the live mux is forwarded until the hold register
    // has loaded.
    logic [7:0] rd_byte_live;
    logic [7:0] rd_byte_q;
    logic       data_oe;

    assign rd_byte_live = (lo_addr_s[0] == SEL_HI) ? trap_addr_q[15:8]
                                                   : trap_addr_q[7:0];

    always_ff @(posedge clk) begin
        if (reset)             rd_byte_q <= '0;
        else if (rd_start_evt) rd_byte_q <= rd_byte_live;
    end

    assign data_oe = ~rd_sync;

    // ---------------- overrun counter ----------------
    logic [3:0] overrun_cnt;
`ifdef MAPPER_OVERRUN_EN
    logic [3:0] overrun_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= '0;
        end else if (state_q != ST_IDLE && state_d == ST_IDLE) begin
            overrun_q <= '0;
        end else if (overrun_evt && overrun_q != 4'd15) begin
            overrun_q <= overrun_q + 4'd1;
        end
    end
    assign overrun_cnt = overrun_q;
`else
    logic unused_overrun;
    assign unused_overrun = overrun_evt;
    assign overrun_cnt    = 4'd0;
`endif

    // ---------------- outputs ----------------
    assign bus.data_oe      = data_oe;
    assign bus.data_out     = !data_oe     ? 8'h00 :
                              rd_start_evt ? rd_byte_live : rd_byte_q;
    assign bus.phys_page    = phys_page_q;
    assign bus.trap_pending = (state_q != ST_IDLE);
    assign bus.overrun_cnt  = overrun_cnt;
endmodule

// File: tb/tb_mapper_xlate.sv
// tb_mapper_xlate: directed self-checking bench for mapper_xlate
// (PAGE_BITS=8, SYNC_STAGES=2). Expected overrun values follow
// MAPPER_OVERRUN_EN when the bench is compiled with the same define.
module tb_mapper_xlate;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

`ifdef MAPPER_OVERRUN_EN
    localparam logic [3:0] OVR_ONE = 4'd1;
    localparam logic [3:0] OVR_SAT = 4'd15;
`else
    localparam logic [3:0] OVR_ONE = 4'd0;
    localparam logic [3:0] OVR_SAT = 4'd0;
`endif

    mapper_xlate_if #(.PAGE_BITS(8)) bus ();

    mapper_xlate #(.PAGE_BITS(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Full read transaction: strobe low, check enable latency and the held
    // byte, strobe high, check release and trap_pending afterwards.
    task automatic read_byte(input string tag, input logic sel, input logic [7:0] exp,
                             input logic exp_pend);
        bus.lo_addr        = {1'b0, sel};
        bus.trap_addr_rd_n = 1'b0;
        tick(1);
        chk({tag, "_oe_early"}, 32'(bus.data_oe), 32'd0);
        tick(1);
        chk({tag, "_oe"}, 32'(bus.data_oe), 32'd1);
        chk({tag, "_data"}, 32'(bus.data_out), 32'(exp));
        tick(2);
        chk({tag, "_data_hold"}, 32'(bus.data_out), 32'(exp));
        bus.trap_addr_rd_n = 1'b1;
        tick(2);
        chk({tag, "_oe_off"}, 32'(bus.data_oe), 32'd0);
        chk({tag, "_data_off"}, 32'(bus.data_out), 32'd0);
        tick(1);
        chk({tag, "_pending"}, 32'(bus.trap_pending), 32'(exp_pend));
        $display("read   sel=%0d exp=0x%02h pending_after=%0d", sel, exp, exp_pend);
    endtask

    task automatic violate(input logic [15:0] addr);
        bus.cpu_addr       = addr;
        bus.trap_addr_wr_n = 1'b0;
        tick(3);
        bus.trap_addr_wr_n = 1'b1;
        tick(2);
        $display("viol   addr=0x%04h", addr);
    endtask

    task automatic capture(input logic [15:0] addr);
        bus.cpu_addr     = addr;
        bus.capture_addr = 1'b1;
        tick(3);
        bus.capture_addr = 1'b0;
        tick(3);
    endtask

    task automatic bank_write(input logic [1:0] idx, input logic [7:0] val);
        bus.lo_addr   = idx;
        bus.data_in   = val;
        bus.bank_wr_n = 1'b0;
        tick(3);
        bus.bank_wr_n = 1'b1;
        tick(2);
        $display("bankwr bank=%0d val=0x%02h", idx, val);
    endtask

    initial begin
        reset              = 1'b1;
        bus.cpu_addr       = 16'h0000;
        bus.data_in        = 8'h00;
        bus.lo_addr        = 2'd0;
        bus.bank_wr_n      = 1'b1;
        bus.trap_addr_wr_n = 1'b1;
        bus.trap_addr_rd_n = 1'b1;
        bus.capture_addr   = 1'b0;
        bus.translate_addr = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state
        chk("rst_data_out", 32'(bus.data_out), 32'd0);
        chk("rst_data_oe", 32'(bus.data_oe), 32'd0);
        chk("rst_phys_page", 32'(bus.phys_page), 32'd0);
        chk("rst_pending", 32'(bus.trap_pending), 32'd0);
        chk("rst_overrun", 32'(bus.overrun_cnt), 32'd0);

        // Identity translation of page 3
        bus.translate_addr = 1'b1;
        bus.cpu_addr       = 16'hC123;
        tick(1);
        chk("xlate_ident", 32'(bus.phys_page), 32'h03);
        $display("xlate  addr=0xC123 exp=0x03");

        // bank[3]=0x5A while page 3 is being translated: old value in the
        // write cycle, new value the cycle after
        bus.lo_addr   = 2'd3;
        bus.data_in   = 8'h5A;
        bus.bank_wr_n = 1'b0;
        tick(3);
        chk("bankwr_same_cycle", 32'(bus.phys_page), 32'h03);
        tick(1);
        chk("bankwr_next_cycle", 32'(bus.phys_page), 32'h5A);
        bus.bank_wr_n = 1'b1;
        tick(2);
        $display("bankwr bank=3 val=0x5a");

        // Translation disabled: raw page number
        bus.translate_addr = 1'b0;
        tick(1);
        chk("xlate_off", 32'(bus.phys_page), 32'h03);
        bus.translate_addr = 1'b1;
        tick(1);

        // Violation latency and full readback
        bus.cpu_addr       = 16'h8042;
        bus.trap_addr_wr_n = 1'b0;
        tick(2);
        chk("viol_pending_early", 32'(bus.trap_pending), 32'd0);
        tick(1);
        chk("viol_pending", 32'(bus.trap_pending), 32'd1);
        bus.trap_addr_wr_n = 1'b1;
        tick(2);
        $display("viol   addr=0x8042");
        read_byte("t2_lo", 1'b0, 8'h42, 1'b1);
        read_byte("t2_hi", 1'b1, 8'h80, 1'b0);

        // Capture while HELD_LO is dropped
        violate(16'h8042);
        capture(16'h1234);
        chk("t3_overrun", 32'(bus.overrun_cnt), 32'(OVR_ONE));
        chk("t3_pending", 32'(bus.trap_pending), 32'd1);
        read_byte("t3_lo", 1'b0, 8'h42, 1'b1);
        chk("t3_overrun_hi", 32'(bus.overrun_cnt), 32'(OVR_ONE));
        read_byte("t3_hi", 1'b1, 8'h80, 1'b0);
        chk("t3_overrun_clr", 32'(bus.overrun_cnt), 32'd0);

        // 17 lost captures saturate the counter
        violate(16'h4000);
        for (int i = 0; i < 17; i++) begin
            capture(16'(16'h1000 + i));
        end
        chk("t4_overrun_sat", 32'(bus.overrun_cnt), 32'(OVR_SAT));
        read_byte("t4_lo", 1'b0, 8'h00, 1'b1);
        read_byte("t4_hi", 1'b1, 8'h40, 1'b0);
        chk("t4_overrun_clr", 32'(bus.overrun_cnt), 32'd0);

        // High-byte read end coincident with a capture at 0x2000
        violate(16'h8042);
        read_byte("t5_lo", 1'b0, 8'h42, 1'b1);
        capture(16'h1111);
        chk("t5_overrun_pre", 32'(bus.overrun_cnt), 32'(OVR_ONE));
        bus.lo_addr        = 2'd1;
        bus.trap_addr_rd_n = 1'b0;
        tick(2);
        chk("t5_hi_data", 32'(bus.data_out), 32'h80);
        tick(2);
        bus.trap_addr_rd_n = 1'b1;
        bus.capture_addr   = 1'b1;
        bus.cpu_addr       = 16'h2000;
        tick(3);
        chk("t5_pending", 32'(bus.trap_pending), 32'd1);
        chk("t5_overrun_keep", 32'(bus.overrun_cnt), 32'(OVR_ONE));
        bus.capture_addr = 1'b0;
        tick(3);
        $display("coinc  hi-read-end + capture addr=0x2000");
        read_byte("t5_new_lo", 1'b0, 8'h00, 1'b1);
        read_byte("t5_new_hi", 1'b1, 8'h20, 1'b0);

        // Reset while HELD_HI restores identity banks and idles the FSM
        bank_write(2'd2, 8'h77);
        bus.cpu_addr = 16'h8000;
        tick(1);
        chk("t6_bank2_mod", 32'(bus.phys_page), 32'h77);
        violate(16'h8000);
        read_byte("t6_lo", 1'b0, 8'h00, 1'b1);
        bus.lo_addr        = 2'd1;
        bus.trap_addr_rd_n = 1'b0;
        tick(2);
        chk("t6_oe_before_rst", 32'(bus.data_oe), 32'd1);
        reset = 1'b1;
        tick(1);
        chk("t6_rst_pending", 32'(bus.trap_pending), 32'd0);
        chk("t6_rst_oe", 32'(bus.data_oe), 32'd0);
        chk("t6_rst_data", 32'(bus.data_out), 32'd0);
        chk("t6_rst_phys", 32'(bus.phys_page), 32'd0);
        bus.trap_addr_rd_n = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("t6_bank2_ident", 32'(bus.phys_page), 32'h02);
        tick(3);
        chk("t6_pending_after", 32'(bus.trap_pending), 32'd0);
        chk("t6_oe_after", 32'(bus.data_oe), 32'd0);
        $display("reset  while HELD_HI");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
